// File: rtl/seq_divider_n.sv
// rtl/seq_divider_n.sv - parametrised restoring divider, one quotient bit per clock
// Two's-complement operation is compiled in only when SEQ_DIVIDER_N_SIGNED_EN is defined.
module seq_divider_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] part_quot;
  logic [WIDTH-1:0] divisor;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  // Carry-out of the widened subtract tells whether the divisor fits.
  always_comb begin
    shifted = {part_rem, part_quot[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_next  = trial[WIDTH-1:0];
      quot_next = {part_quot[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = shifted[WIDTH-1:0];
      quot_next = {part_quot[WIDTH-2:0], 1'b0};
    end
  end

`ifdef SEQ_DIVIDER_N_SIGNED_EN
  logic neg_quot;
  logic neg_rem;

  always_comb begin
    x_mag    = (signed_op && X[WIDTH-1]) ? -X : X;
    y_mag    = (signed_op && Y[WIDTH-1]) ? -Y : Y;
    quot_fix = neg_quot ? -quot_next : quot_next;
    rem_fix  = neg_rem ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_quot <= signed_op && (X[WIDTH-1] ^ Y[WIDTH-1]);
      neg_rem  <= signed_op && X[WIDTH-1];
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign x_mag    = X;
  assign y_mag    = Y;
  assign quot_fix = quot_next;
  assign rem_fix  = rem_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      part_rem    <= '0;
      part_quot   <= '0;
      divisor     <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (Y == '0) begin
              // The raw dividend rides in part_rem until DONE publishes it.
              part_rem <= X;
              state    <= DONE;
            end else begin
              part_rem  <= '0;
              part_quot <= x_mag;
              divisor   <= y_mag;
              count     <= '0;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          part_rem  <= rem_next;
          part_quot <= quot_next;
          count     <= count + CW'(1);
          if (count == LAST) begin
            quot        <= quot_fix;
            rem         <= rem_fix;
            div_by_zero <= 1'b0;
            valid       <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        DONE: begin
          quot        <= '1;
          rem         <= part_rem;
          div_by_zero <= 1'b1;
          valid       <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_n.sv
// tb/tb_seq_divider_n.sv - self-checking bench for seq_divider_n
// Signed expectations follow SEQ_DIVIDER_N_SIGNED_EN when it is defined for the build.
module tb_seq_divider_n;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         valid;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_divider_n #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_op(signed_op),
    .X(X),
    .Y(Y),
    .busy(busy),
    .valid(valid),
    .quot(quot),
    .rem(rem),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, signed truncation toward zero via int arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (y == 0) return {{W{1'b1}}, x, 1'b1};
`ifdef SEQ_DIVIDER_N_SIGNED_EN
    if (s) begin
      int sx;
      int sy;
      sx = int'($signed(x));
      sy = int'($signed(y));
      q  = W'(sx / sy);
      r  = W'(sx % sy);
      return {q, r, 1'b0};
    end
`else
    begin
      logic unused_s;
      unused_s = s;
    end
`endif
    q = x / y;
    r = x % y;
    return {q, r, 1'b0};
  endfunction

  // Launch one divide, scramble the operands after acceptance, and check the result.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; X = x; Y = y; signed_op = s;
    @(negedge clk);
    start = 1'b0; X = W'($urandom); Y = W'($urandom); signed_op = 1'($urandom);
    check({name, "_busy"}, busy, 1);
    seen = 0;
    lat  = 0;
    for (int i = 1; i <= W + 4 && !seen; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1;
        lat  = i;
      end
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_lat"}, lat, (y == 0) ? 1 : W);
    check({name, "_quot"}, quot, eq);
    check({name, "_rem"}, rem, er);
    check({name, "_dbz"}, div_by_zero, ez);
    check({name, "_busy_done"}, busy, 0);
    @(negedge clk);
    check({name, "_pulse"}, valid, 0);
  endtask

  vec_t tbl[8];

  initial begin
    logic [2*W:0] m;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rs;
    int           vidx[$];
    int           nvalid;

    tbl[0] = '{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0};
    tbl[1] = '{8'd13,  8'd0,   1'b0, 8'hFF,  8'd13,  1'b1};
    tbl[2] = '{8'd255, 8'd16,  1'b0, 8'd15,  8'd15,  1'b0};
    tbl[3] = '{8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0};
    tbl[4] = '{8'd5,   8'd200, 1'b0, 8'd0,   8'd5,   1'b0};
    tbl[5] = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0};
`ifdef SEQ_DIVIDER_N_SIGNED_EN
    tbl[6] = '{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0};
    tbl[7] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0};
`else
    tbl[6] = '{8'hF9,  8'd2,   1'b1, 8'd124, 8'd1,   1'b0};
    tbl[7] = '{8'h80,  8'hFF,  1'b1, 8'd0,   8'h80,  1'b0};
`endif

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; X = '0; Y = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].q, tbl[i].r, tbl[i].z);

    // Divide-by-zero result must hold through idle cycles.
    run_op("dbz", 8'd13, 8'd0, 1'b0, 8'hFF, 8'd13, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_quot", quot, 8'hFF);
    check("hold_rem", rem, 8'd13);
    check("hold_dbz", div_by_zero, 1);
    check("hold_valid", valid, 0);

    for (int k = 0; k < 40; k++) begin
      rx = W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rs = 1'($urandom);
      m  = model(rx, ry, rs);
      run_op($sformatf("rnd%0d", k), rx, ry, rs, m[2*W:W+1], m[W:1], m[0]);
    end

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; X = 8'd100; Y = 8'd9; signed_op = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        check("swb_edge", i, 8);
        check("swb_quot", quot, 8'd11);
        check("swb_rem", rem, 8'd1);
      end
      if (i == 3) begin
        start = 1'b1; X = 8'd50; Y = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    check("swb_count", nvalid, 1);

    // Back-to-back with start held high.
    start = 1'b1; X = 8'd255; Y = 8'd16; signed_op = 1'b0;
    vidx.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) begin
        vidx.push_back(i);
        check("b2b_quot", quot, 8'd15);
        check("b2b_rem", rem, 8'd15);
      end
    end
    start = 1'b0;
    check("b2b_count", vidx.size(), 3);
    if (vidx.size() == 3) begin
      check("b2b_first", vidx[0], 8);
      check("b2b_gap1", vidx[1] - vidx[0], 9);
      check("b2b_gap2", vidx[2] - vidx[1], 9);
    end
    for (int i = 0; i < 12 && busy; i++) @(negedge clk);
    check("b2b_drain", busy, 0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; X = 8'd200; Y = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_valid", valid, 0);
    check("mid_quot", quot, 0);
    check("mid_rem", rem, 0);
    check("mid_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("mid_novalid", nvalid, 0);
    run_op("after_rst", 8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_n.md
# seq_divider_n

Parametrised multi-cycle restoring divider, the successor to the fixed 4-bit sequential divider in the Mini-SRC datapath. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock. It adds a busy/valid handshake, result hold, divide-by-zero detection and optional signed operation. It sits beside the ALU and serves DIV instructions while the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal values are 2 to 32.
- `clk`  input  1  rising-edge clock; the only clock in the block.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to begin a division. Sampled on rising edges of `clk`.
- `signed_op`  input  1  1 selects a two's-complement divide. Sampled with `start`.
- `X`  input  WIDTH  dividend.
- `Y`  input  WIDTH  divisor.
- `busy`  output  1  high while a division is in progress.
- `valid`  output  1  one-cycle pulse marking that a new result is present.
- `quot`  output  WIDTH  quotient.
- `rem`  output  WIDTH  remainder.
- `div_by_zero`  output  1  set with `valid` when `Y` was 0. Holds with the result.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 with `Y`≠0: latch operands, clear the count, enter RUN.
  - `start`=1 with `Y`=0: enter DONE and load the divide-by-zero result.
- **RUN**, one iteration per cycle, WIDTH iterations:
  - Shift the {partial remainder, quotient} pair left by one.
  - Trial-subtract the divisor magnitude in WIDTH+1 bits.
  - If the difference is non-negative: keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After the WIDTH-th iteration, apply sign fix-up in the same cycle, write `quot`/`rem`, and return to IDLE.
- **DONE** exists only for the divide-by-zero path. It writes the result and returns to IDLE after one cycle.
- Iteration counter width is $clog2(WIDTH+1). The counter must not wrap before WIDTH iterations complete.
- `start` while `busy`=1 is ignored. Operands are not re-sampled, and the current division is unaffected.
- `quot`, `rem` and `div_by_zero` hold their last result until the next completion. They are not cleared on return to IDLE.
- Divide by zero:
  - `quot` = all ones.
  - `rem` = dividend `X` as given.
  - `div_by_zero` = 1.
- Any non-zero-divisor completion clears `div_by_zero`.
- Unsigned: the standard floor divide; X = quot·Y + rem with 0 ≤ rem < Y.

## Timing
- Reset values: `busy`=0, `valid`=0, `quot`=0, `rem`=0, `div_by_zero`=0, state IDLE, counter 0.
- Reset asserted mid-division aborts immediately. No `valid` is produced.
- Edge E0 accepts `start`. `busy` is 1 from E0 to E(WIDTH).
- At edge E(WIDTH):
  - `quot`/`rem` update.
  - `valid`=1 for exactly one cycle.
  - `busy`=0.
- Latency is WIDTH cycles from acceptance to valid.
- Divide by zero: `busy`=1 for one cycle; `valid` and the result arrive at E1.
- A `start` present during the `valid` cycle is accepted at the next edge. Back-to-back throughput is one result per WIDTH+1 cycles.
- `X`, `Y` and `signed_op` need only be stable at the accepting edge.

## Configuration
- Macro: `SEQ_DIVIDER_N_SIGNED_EN`.
- **Defined:** `signed_op`=1 performs a two's-complement divide.
  - Operands are converted to magnitudes at acceptance, and the unsigned core runs on the magnitudes.
  - The quotient is negated when the operand signs differ, so it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative ÷ −1 yields `quot` = most-negative and `rem` = 0, with no flag.
  - Latency is unchanged.
- **Undefined:** `signed_op` is ignored and treated as 0. All operations are unsigned, with no magnitude or negate logic. The port remains present.

## Test plan
- **Unsigned divide:** WIDTH=8, X=200, Y=7, `start` pulse → `busy` for 8 cycles; at E8 `valid` pulses, `quot`=28, `rem`=4, `div_by_zero`=0.
- **Divide by zero:** X=13, Y=0 → at E1 `valid`=1, `quot`=0xFF, `rem`=13, `div_by_zero`=1. Outputs hold afterwards with `valid`=0.
- **Signed, with macro:** X=0xF9 (−7), Y=2, `signed_op`=1 → `quot`=0xFD (−3), `rem`=0xFF (−1). Also X=0x80, Y=0xFF → `quot`=0x80, `rem`=0.
- **Start while busy:** X=100, Y=9 accepted; at cycle 3 drive `start` with X=50, Y=5 → `valid` only at E8 with `quot`=11, `rem`=1, and no second result.
- **Back-to-back:** hold `start`=1 continuously with 255/16 → `quot`=15, `rem`=15. Valid pulses recur every 9 cycles.
- **Reset mid-op:** assert `rst` at cycle 4 of a divide → all outputs 0 immediately; no `valid` after release. A fresh 9/3 then yields `quot`=3, `rem`=0.
